// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: ID/EX-to-EX/MEM bus for ex_mem_stage (decoded inputs, stall and registered outputs)
interface ex_mem_stage_if;
    logic        valid_i;
    logic [31:0] val1_i;
    logic [31:0] val2_i;
    logic [3:0]  ALUCtrl_i;
    logic [31:0] store_data_i;
    logic [4:0]  rd_addr_i;
    logic [1:0]  Mem_i;
    logic        WB_i;
    logic        stall_o;
    logic        valid_o;
    logic [31:0] ALU_result_o;
    logic [31:0] store_data_o;
    logic [4:0]  rd_addr_o;
    logic [1:0]  Mem_o;
    logic        WB_o;

    modport master (
        output valid_i, val1_i, val2_i, ALUCtrl_i, store_data_i, rd_addr_i, Mem_i, WB_i,
        input  stall_o, valid_o, ALU_result_o, store_data_o, rd_addr_o, Mem_o, WB_o
    );

    modport slave (
        input  valid_i, val1_i, val2_i, ALUCtrl_i, store_data_i, rd_addr_i, Mem_i, WB_i,
        output stall_o, valid_o, ALU_result_o, store_data_o, rd_addr_o, Mem_o, WB_o
    );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage + EX/MEM register; MUL is iterative shift-add unless EX_FAST_MUL_EN is defined
module ex_mem_stage #(
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input logic           clk_i,
    input logic           rst_i,
    ex_mem_stage_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b1111;

    logic        is_mul;
    logic [31:0] mul_res;
    logic [31:0] alu_res;

    assign is_mul = bus.ALUCtrl_i == OP_MUL;

`ifdef EX_FAST_MUL_EN
    assign mul_res = bus.val1_i * bus.val2_i;
`else
    assign mul_res = '0;
`endif

    // Single-cycle ALU; unknown codes give zero
    always_comb begin
        alu_res = bus.ALUCtrl_i == OP_ADD ? bus.val1_i + bus.val2_i :
                  bus.ALUCtrl_i == OP_SUB ? bus.val1_i - bus.val2_i :
                  bus.ALUCtrl_i == OP_AND ? bus.val1_i & bus.val2_i :
                  bus.ALUCtrl_i == OP_OR  ? bus.val1_i | bus.val2_i :
                  is_mul                  ? mul_res : '0;
    end

`ifdef EX_FAST_MUL_EN
    assign bus.stall_o = 1'b0;

    // EX/MEM register: every valid op completes in one cycle, otherwise a bubble
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.valid_o      <= 1'b0;
            bus.ALU_result_o <= '0;
            bus.store_data_o <= '0;
            bus.rd_addr_o    <= '0;
            bus.Mem_o        <= '0;
            bus.WB_o         <= 1'b0;
        end else if (bus.valid_i) begin
            bus.valid_o      <= 1'b1;
            bus.ALU_result_o <= alu_res;
            bus.store_data_o <= bus.store_data_i;
            bus.rd_addr_o    <= bus.rd_addr_i;
            bus.Mem_o        <= bus.Mem_i;
            bus.WB_o         <= bus.WB_i;
        end else begin
            bus.valid_o <= 1'b0;
            bus.Mem_o   <= '0;
            bus.WB_o    <= 1'b0;
        end
    end
`else
    localparam int          N          = 32 / MUL_BITS_PER_CYCLE;
    localparam logic [31:0] DIGIT_MASK = 32'((64'd1 << MUL_BITS_PER_CYCLE) - 64'd1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t      state, state_nx;
    logic [5:0]  cnt;
    logic [31:0] mcand, mplier, acc, acc_nx;
    logic [31:0] cap_sd;
    logic [4:0]  cap_rd;
    logic [1:0]  cap_mem;
    logic        cap_wb;
    logic        last, issue_mul, stall;

    assign last        = state == MUL && cnt == 6'(N - 1);
    assign issue_mul   = state == IDLE && bus.valid_i && is_mul;
    assign acc_nx      = acc + mcand * (mplier & DIGIT_MASK);
    assign bus.stall_o = stall && !rst_i;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state and stall: hold upstream from MUL issue until the final digit cycle
    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        if (state == IDLE) begin
            state_nx = issue_mul ? MUL : IDLE;
            stall    = issue_mul;
        end else begin
            state_nx = last ? IDLE : MUL;
            stall    = !last;
        end
    end

    // Multiplier datapath: capture operands on issue, retire one digit (LSB first) per MUL cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            cap_sd  <= '0;
            cap_rd  <= '0;
            cap_mem <= '0;
            cap_wb  <= 1'b0;
        end else if (issue_mul) begin
            mcand   <= bus.val1_i;
            mplier  <= bus.val2_i;
            acc     <= '0;
            cnt     <= '0;
            cap_sd  <= bus.store_data_i;
            cap_rd  <= bus.rd_addr_i;
            cap_mem <= bus.Mem_i;
            cap_wb  <= bus.WB_i;
        end else if (state == MUL) begin
            acc    <= acc_nx;
            mcand  <= mcand << MUL_BITS_PER_CYCLE;
            mplier <= mplier >> MUL_BITS_PER_CYCLE;
            cnt    <= cnt + 6'd1;
        end
    end

    // EX/MEM register: product on the last MUL cycle, ALU result on a plain issue, bubble otherwise
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.valid_o      <= 1'b0;
            bus.ALU_result_o <= '0;
            bus.store_data_o <= '0;
            bus.rd_addr_o    <= '0;
            bus.Mem_o        <= '0;
            bus.WB_o         <= 1'b0;
        end else if (last) begin
            bus.valid_o      <= 1'b1;
            bus.ALU_result_o <= acc_nx;
            bus.store_data_o <= cap_sd;
            bus.rd_addr_o    <= cap_rd;
            bus.Mem_o        <= cap_mem;
            bus.WB_o         <= cap_wb;
        end else if (state == IDLE && bus.valid_i && !is_mul) begin
            bus.valid_o      <= 1'b1;
            bus.ALU_result_o <= alu_res;
            bus.store_data_o <= bus.store_data_i;
            bus.rd_addr_o    <= bus.rd_addr_i;
            bus.Mem_o        <= bus.Mem_i;
            bus.WB_o         <= bus.WB_i;
        end else begin
            bus.valid_o <= 1'b0;
            bus.Mem_o   <= '0;
            bus.WB_o    <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed and randomized checks of ex_mem_stage; honours EX_FAST_MUL_EN
module tb_ex_mem_stage;
    localparam int MBPC = 1;
    localparam int N    = 32 / MBPC;
`ifdef EX_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam int LAT = FAST ? 1 : N + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ex_mem_stage_if ex_if ();

    ex_mem_stage #(.MUL_BITS_PER_CYCLE(MBPC)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (ex_if)
    );

    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] sd, input logic [4:0] rd, input logic [1:0] mem, input logic wb);
        ex_if.valid_i      = v;
        ex_if.ALUCtrl_i    = c;
        ex_if.val1_i       = a;
        ex_if.val2_i       = b;
        ex_if.store_data_i = sd;
        ex_if.rd_addr_i    = rd;
        ex_if.Mem_i        = mem;
        ex_if.WB_i         = wb;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (c)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b1111: return p[31:0];
            default: return 32'd0;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 4'b1111, 32'd9, 32'd9, 32'hABCD, 5'd9, 2'b11, 1'b1);
        #12;
        checks += 7;
        if (ex_if.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", ex_if.valid_o); end
        if (ex_if.ALU_result_o !== 32'd0) begin errors++; $display("FAIL reset_res got %h expected 0", ex_if.ALU_result_o); end
        if (ex_if.store_data_o !== 32'd0) begin errors++; $display("FAIL reset_sd got %h expected 0", ex_if.store_data_o); end
        if (ex_if.rd_addr_o !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d expected 0", ex_if.rd_addr_o); end
        if (ex_if.Mem_o !== 2'b00) begin errors++; $display("FAIL reset_mem got %b expected 00", ex_if.Mem_o); end
        if (ex_if.WB_o !== 1'b0) begin errors++; $display("FAIL reset_wb got %b expected 0", ex_if.WB_o); end
        if (ex_if.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b expected 0", ex_if.stall_o); end
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 5'd0, 2'b00, 1'b0);
        #1 rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_alu();
        logic [3:0]  codes [4] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001};
        logic [31:0] va    [4] = '{32'd5, 32'd3, 32'hF0F0F0F0, 32'hF0F0F0F0};
        logic [31:0] vb    [4] = '{32'd7, 32'd5, 32'h0FF00FF0, 32'h0FF00FF0};
        logic [31:0] exp   [4] = '{32'd12, 32'hFFFFFFFE, 32'h00F000F0, 32'hFFF0FFF0};
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1'b1, codes[i], va[i], vb[i], 32'h100 + 32'(i), 5'(i + 3), 2'b00, 1'b1);
            else drive(1'b0, 4'b0010, 32'd0, 32'd0, 32'd0, 5'd0, 2'b00, 1'b0);
            @(negedge clk);
            checks++;
            if (ex_if.stall_o !== 1'b0) begin errors++; $display("FAIL alu_stall op %0d got %b expected 0", i, ex_if.stall_o); end
            if (i > 0) begin
                checks += 5;
                if (ex_if.valid_o !== 1'b1) begin errors++; $display("FAIL alu_valid op %0d got %b expected 1", i - 1, ex_if.valid_o); end
                if (ex_if.ALU_result_o !== exp[i-1]) begin errors++; $display("FAIL alu_res op %0d got %h expected %h", i - 1, ex_if.ALU_result_o, exp[i-1]); end
                if (ex_if.rd_addr_o !== 5'(i + 2)) begin errors++; $display("FAIL alu_rd op %0d got %0d expected %0d", i - 1, ex_if.rd_addr_o, i + 2); end
                if (ex_if.WB_o !== 1'b1) begin errors++; $display("FAIL alu_wb op %0d got %b expected 1", i - 1, ex_if.WB_o); end
                if (ex_if.store_data_o !== 32'h100 + 32'(i - 1)) begin errors++; $display("FAIL alu_sd op %0d got %h expected %h", i - 1, ex_if.store_data_o, 32'h100 + 32'(i - 1)); end
            end
            next_cycle();
        end
    endtask

    task automatic test_undefined();
        drive(1'b1, 4'b1000, 32'd77, 32'd88, 32'h55, 5'd12, 2'b10, 1'b0);
        next_cycle();
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 5'd0, 2'b00, 1'b0);
        @(negedge clk);
        checks += 4;
        if (ex_if.valid_o !== 1'b1) begin errors++; $display("FAIL undef_valid got %b expected 1", ex_if.valid_o); end
        if (ex_if.ALU_result_o !== 32'd0) begin errors++; $display("FAIL undef_res got %h expected 0", ex_if.ALU_result_o); end
        if (ex_if.Mem_o !== 2'b10) begin errors++; $display("FAIL undef_mem got %b expected 10", ex_if.Mem_o); end
        if (ex_if.rd_addr_o !== 5'd12) begin errors++; $display("FAIL undef_rd got %0d expected 12", ex_if.rd_addr_o); end
        next_cycle();
        @(negedge clk);
        checks += 3;
        if (ex_if.valid_o !== 1'b0) begin errors++; $display("FAIL bubble_valid got %b expected 0", ex_if.valid_o); end
        if (ex_if.Mem_o !== 2'b00) begin errors++; $display("FAIL bubble_mem got %b expected 00", ex_if.Mem_o); end
        if (ex_if.rd_addr_o !== 5'd12) begin errors++; $display("FAIL bubble_rd_hold got %0d expected 12", ex_if.rd_addr_o); end
        next_cycle();
    endtask

    task automatic test_mul();
        for (int k = 0; k <= LAT; k++) begin
            if (k < LAT) drive(1'b1, 4'b1111, 32'd7, 32'd6, 32'h77, 5'd8, 2'b00, 1'b1);
            else drive(1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 5'd0, 2'b00, 1'b0);
            @(negedge clk);
            checks++;
            if (ex_if.stall_o !== (!FAST && k < N)) begin errors++; $display("FAIL mul_stall cycle %0d got %b expected %b", k, ex_if.stall_o, (!FAST && k < N)); end
            if (k > 0) begin
                checks++;
                if (ex_if.valid_o !== (k == LAT)) begin errors++; $display("FAIL mul_valid cycle %0d got %b expected %b", k, ex_if.valid_o, k == LAT); end
            end
            if (k == LAT) begin
                checks += 3;
                if (ex_if.ALU_result_o !== 32'd42) begin errors++; $display("FAIL mul_res got %0d expected 42", ex_if.ALU_result_o); end
                if (ex_if.rd_addr_o !== 5'd8) begin errors++; $display("FAIL mul_rd got %0d expected 8", ex_if.rd_addr_o); end
                if (ex_if.WB_o !== 1'b1) begin errors++; $display("FAIL mul_wb got %b expected 1", ex_if.WB_o); end
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        bit done = 1'b0;
        drive(1'b1, 4'b1111, 32'hFFFFFFFF, 32'd2, 32'h0, 5'd4, 2'b00, 1'b1);
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            done = ex_if.stall_o === 1'b0;
            next_cycle();
        end
        checks++;
        if (!done) begin errors++; $display("FAIL b2b_stall_timeout got stall=1 expected release within 100 cycles"); end
        drive(1'b1, 4'b0010, 32'd1, 32'd1, 32'h0, 5'd5, 2'b01, 1'b1);
        @(negedge clk);
        checks += 4;
        if (ex_if.valid_o !== 1'b1) begin errors++; $display("FAIL b2b_mul_valid got %b expected 1", ex_if.valid_o); end
        if (ex_if.ALU_result_o !== 32'hFFFFFFFE) begin errors++; $display("FAIL b2b_mul_res got %h expected fffffffe", ex_if.ALU_result_o); end
        if (ex_if.rd_addr_o !== 5'd4) begin errors++; $display("FAIL b2b_mul_rd got %0d expected 4", ex_if.rd_addr_o); end
        if (ex_if.Mem_o !== 2'b00) begin errors++; $display("FAIL b2b_mul_mem got %b expected 00", ex_if.Mem_o); end
        next_cycle();
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 5'd0, 2'b00, 1'b0);
        @(negedge clk);
        checks += 5;
        if (ex_if.valid_o !== 1'b1) begin errors++; $display("FAIL b2b_add_valid got %b expected 1", ex_if.valid_o); end
        if (ex_if.ALU_result_o !== 32'd2) begin errors++; $display("FAIL b2b_add_res got %h expected 2", ex_if.ALU_result_o); end
        if (ex_if.rd_addr_o !== 5'd5) begin errors++; $display("FAIL b2b_add_rd got %0d expected 5", ex_if.rd_addr_o); end
        if (ex_if.Mem_o !== 2'b01) begin errors++; $display("FAIL b2b_add_mem got %b expected 01", ex_if.Mem_o); end
        if (ex_if.WB_o !== 1'b1) begin errors++; $display("FAIL b2b_add_wb got %b expected 1", ex_if.WB_o); end
        next_cycle();
    endtask

    task automatic test_reset_mid_mul();
        drive(1'b1, 4'b0010, 32'd9, 32'd9, 32'h1234, 5'd7, 2'b01, 1'b1);
        next_cycle();
        drive(1'b1, 4'b1111, 32'd3, 32'd3, 32'h99, 5'd6, 2'b00, 1'b1);
        for (int k = 0; k < 10; k++) next_cycle();
        #2 rst = 1'b1;
        #1;
        checks += 6;
        if (ex_if.valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b expected 0", ex_if.valid_o); end
        if (ex_if.ALU_result_o !== 32'd0) begin errors++; $display("FAIL midrst_res got %h expected 0", ex_if.ALU_result_o); end
        if (ex_if.store_data_o !== 32'd0) begin errors++; $display("FAIL midrst_sd got %h expected 0", ex_if.store_data_o); end
        if (ex_if.rd_addr_o !== 5'd0) begin errors++; $display("FAIL midrst_rd got %0d expected 0", ex_if.rd_addr_o); end
        if (ex_if.WB_o !== 1'b0) begin errors++; $display("FAIL midrst_wb got %b expected 0", ex_if.WB_o); end
        if (ex_if.stall_o !== 1'b0) begin errors++; $display("FAIL midrst_stall got %b expected 0", ex_if.stall_o); end
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 5'd0, 2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        for (int k = 0; k < N + 5; k++) begin
            @(negedge clk);
            checks++;
            if (ex_if.valid_o !== 1'b0) begin errors++; $display("FAIL midrst_ghost cycle %0d got valid %b expected 0", k, ex_if.valid_o); end
            next_cycle();
        end
    endtask

    task automatic test_random();
        logic        v, m_valid, m_wb, p_wb, exp_stall, hold;
        logic [3:0]  c;
        logic [31:0] a, b, sd, m_res, m_sd, p_res, p_sd;
        logic [4:0]  rd, m_rd, p_rd;
        logic [1:0]  mem, m_mem, p_mem;
        int          mul_left, r;
        rst = 1'b1;
        #2 rst = 1'b0;
        {m_valid, m_wb, m_res, m_sd, m_rd, m_mem} = '0;
        {p_wb, p_res, p_sd, p_rd, p_mem} = '0;
        mul_left = 0;
        hold = 1'b0;
        {v, c, a, b, sd, rd, mem} = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!hold) begin
                r   = $urandom_range(0, 19);
                v   = $urandom_range(0, 4) != 0;
                c   = r < 5 ? 4'b0010 : r < 9 ? 4'b0110 : r < 13 ? 4'b0000 : r < 17 ? 4'b0001 : r == 19 ? 4'b1111 : 4'($urandom);
                a   = $urandom_range(0, 7) == 0 ? 32'hFFFFFFFF : $urandom;
                b   = $urandom_range(0, 7) == 0 ? 32'hFFFFFFFF : $urandom;
                sd  = $urandom;
                rd  = 5'($urandom);
                mem = 2'($urandom);
            end
            drive(v, c, a, b, sd, rd, mem, r[0]);
            exp_stall = mul_left > 0 ? mul_left > 1 : (v && c == 4'b1111 && !FAST);
            @(negedge clk);
            checks += 7;
            if (ex_if.stall_o !== exp_stall) begin errors++; $display("FAIL rnd_stall cycle %0d got %b expected %b", cyc, ex_if.stall_o, exp_stall); end
            if (ex_if.valid_o !== m_valid) begin errors++; $display("FAIL rnd_valid cycle %0d got %b expected %b", cyc, ex_if.valid_o, m_valid); end
            if (ex_if.ALU_result_o !== m_res) begin errors++; $display("FAIL rnd_res cycle %0d got %h expected %h", cyc, ex_if.ALU_result_o, m_res); end
            if (ex_if.store_data_o !== m_sd) begin errors++; $display("FAIL rnd_sd cycle %0d got %h expected %h", cyc, ex_if.store_data_o, m_sd); end
            if (ex_if.rd_addr_o !== m_rd) begin errors++; $display("FAIL rnd_rd cycle %0d got %0d expected %0d", cyc, ex_if.rd_addr_o, m_rd); end
            if (ex_if.Mem_o !== m_mem) begin errors++; $display("FAIL rnd_mem cycle %0d got %b expected %b", cyc, ex_if.Mem_o, m_mem); end
            if (ex_if.WB_o !== m_wb) begin errors++; $display("FAIL rnd_wb cycle %0d got %b expected %b", cyc, ex_if.WB_o, m_wb); end
            hold = exp_stall;
            @(posedge clk);
            if (mul_left > 0) begin
                mul_left--;
                if (mul_left == 0) begin
                    {m_valid, m_res, m_sd, m_rd, m_mem, m_wb} = {1'b1, p_res, p_sd, p_rd, p_mem, p_wb};
                end else begin
                    {m_valid, m_mem, m_wb} = '0;
                end
            end else if (v && c == 4'b1111 && !FAST) begin
                {p_res, p_sd, p_rd, p_mem, p_wb} = {ref_alu(c, a, b), sd, rd, mem, r[0]};
                mul_left = N;
                {m_valid, m_mem, m_wb} = '0;
            end else if (v) begin
                {m_valid, m_res, m_sd, m_rd, m_mem, m_wb} = {1'b1, ref_alu(c, a, b), sd, rd, mem, r[0]};
            end else begin
                {m_valid, m_mem, m_wb} = '0;
            end
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_undefined();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register, directly downstream of the ID/EX decode stage.
- Consumes the operands val1/val2, the 4-bit ALU control code, the store data and the control bits produced by ID/EX.
- Computes the ALU result and registers it with rd address, Mem and WB control bits for the MEM stage.
- MUL runs on an iterative shift-add multiplier and stalls upstream while busy.

Parameters:
- MUL_BITS_PER_CYCLE, 1, multiplier bits retired per MUL cycle; legal values 1, 2, 4, 8, 16, 32.
- N (derived, not overridable) = 32 / MUL_BITS_PER_CYCLE.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- valid_i  input  1  instruction present from ID/EX.
- val1_i  input  32  operand A.
- val2_i  input  32  operand B (rs2 data or immediate, already muxed upstream).
- ALUCtrl_i  input  4  0010 add, 0110 sub, 0000 and, 0001 or, 1111 mul.
- store_data_i  input  32  rs2 data for stores.
- rd_addr_i  input  5  destination register.
- Mem_i  input  2  [1] MemRead, [0] MemWrite.
- WB_i  input  1  RegWrite.
- stall_o  output  1  combinational; upstream holds its inputs while high.
- valid_o  output  1  registered EX/MEM valid.
- ALU_result_o  output  32  registered result / address.
- store_data_o  output  32  registered store data.
- rd_addr_o  output  5  registered.
- Mem_o  output  2  registered.
- WB_o  output  1  registered.

Behaviour:
- Reset (rst_i high, asynchronous): every registered output is 0, FSM goes to IDLE, iteration counter is 0, stall_o is 0.
- FSM states: IDLE, MUL.
- IDLE, valid_i=0: next edge loads a bubble (valid_o, WB_o, Mem_o = 0; other registered outputs hold).
- IDLE, valid_i=1, non-mul code: next edge loads the result and all side fields, valid_o=1. Latency 1 cycle, stall_o=0.
- Arithmetic: add/sub are 32-bit with wraparound, no flags. and/or are bitwise.
- Undefined ALUCtrl codes: result 0; the other fields pass through unchanged.
- IDLE, valid_i=1, ALUCtrl_i=1111:
  - stall_o=1 combinationally in that cycle.
  - Next edge captures val1/val2 and the side fields internally, clears the accumulator, counter=0, state goes to MUL.
  - The EX/MEM register loads a bubble.
- MUL: each cycle retires MUL_BITS_PER_CYCLE multiplier bits (LSB first) into the accumulator; counter increments.
  - stall_o=1 while counter < N-1.
  - Inputs are ignored in MUL.
  - A bubble is loaded on every MUL edge except the last.
- Last MUL cycle (counter = N-1):
  - stall_o=0, so upstream advances on this edge.
  - The edge loads the low 32 bits of the product plus the captured side fields, valid_o=1, state returns to IDLE.
- MUL latency: issued in cycle 0, result visible in cycle N+1 (cycle 33 for default).
- Back-to-back: the instruction following a MUL is presented in the cycle after the result load and is handled as a normal IDLE issue. No dead cycle beyond this.
- Reset mid-MUL: the operation is dropped; no valid_o is ever produced for it.
- Only the low 32 bits of the product are kept; the upper half is discarded.

Optional Feature:
- Macro: EX_FAST_MUL_EN.
- Defined: MUL is a single-cycle combinational 32x32 product (low 32 bits) with latency 1 like the other ops. stall_o is tied 0, the FSM and counter are not built, and MUL_BITS_PER_CYCLE is ignored.
- Undefined: the iterative FSM behaviour above.

Test Plan:
- Reset, then valid_i=1, ALUCtrl=0010, val1=5, val2=7, rd=3, WB=1 -> next cycle valid_o=1, ALU_result_o=12, rd_addr_o=3, WB_o=1, stall_o never high.
- ALUCtrl=0110, val1=3, val2=5 -> result 0xFFFFFFFE. Then 0000 with 0xF0F0F0F0, 0x0FF00FF0 -> 0x00F000F0. Then 0001 with the same operands -> 0xFFF0FFF0.
- Default parameter, ALUCtrl=1111, val1=7, val2=6 -> stall_o high in cycles 0..31, low in cycle 32; valid_o=0 in cycles 1..32; cycle 33 valid_o=1, result 42.
- MUL 0xFFFFFFFF*2, then an add 1+1 presented right after -> results 0xFFFFFFFE then 2 in consecutive cycles; rd/Mem/WB match each instruction.
- MUL issued, rst_i pulsed in cycle 10 -> all outputs 0 immediately (asynchronous), stall_o=0, no later valid_o for that MUL.
- ALUCtrl=1000, Mem_i=2'b10 -> valid_o=1, result 0, Mem_o=2'b10. Re-run the MUL case with EX_FAST_MUL_EN defined -> result 42 after 1 cycle, stall_o constant 0.
